// File: rtl/jam_pkg.sv
// Shared state encodings and width helpers for the job-assignment search engine.
package jam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EVAL = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } top_state_t;

    typedef enum logic [2:0] {
        NS_IDLE    = 3'd0,
        NS_PIVOT   = 3'd1,
        NS_SUCC    = 3'd2,
        NS_SWAP    = 3'd3,
        NS_REVERSE = 3'd4
    } next_state_t;

    localparam int MW = 16;

    function automatic int jam_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int jam_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Permutation register plus the multi-cycle lexicographic next-permutation engine.
module jam_next_perm
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int LW = 3
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_init,
    input  logic            i_start,
    output logic            o_done,
    output logic            o_last,
    output logic [N*LW-1:0] o_perm
);

    localparam int XW = LW + 1;
    localparam logic [LW-1:0] IDX_LAST = LW'(N - 1);
    localparam logic [LW-1:0] IDX_PIV0 = LW'(N - 2);

    next_state_t r_ns, w_ns;
    logic [LW-1:0] r_perm [N];
    logic [LW-1:0] w_perm [N];
    logic [LW-1:0] r_i, w_i, r_j, w_j, r_lo, w_lo, r_hi, w_hi;
    logic [LW-1:0] w_ip1;
    logic          r_done, w_done, r_last, w_last;

    // Next-state and next-datapath values for the permutation engine.
    always_comb begin
        w_ns   = r_ns;
        w_perm = r_perm;
        w_i    = r_i;
        w_j    = r_j;
        w_lo   = r_lo;
        w_hi   = r_hi;
        w_done = 1'b0;
        w_last = r_last;
        w_ip1  = r_i + 1'b1;
        case (r_ns)
            NS_IDLE: begin
                if (i_init) begin
                    for (int k = 0; k < N; k++) begin
                        w_perm[k] = LW'(k);
                    end
                    w_last = 1'b0;
                end else if (i_start) begin
                    w_i    = IDX_PIV0;
                    w_last = 1'b0;
                    w_ns   = NS_PIVOT;
                end else begin
                    w_ns = NS_IDLE;
                end
            end
            NS_PIVOT: begin
                if (r_perm[r_i] < r_perm[w_ip1]) begin
                    w_j  = IDX_LAST;
                    w_ns = NS_SUCC;
                end else if (r_i == {LW{1'b0}}) begin
                    // Descending sequence: the permutation just evaluated was the last one.
                    w_last = 1'b1;
                    w_done = 1'b1;
                    w_ns   = NS_IDLE;
                end else begin
                    w_i = r_i - 1'b1;
                end
            end
            NS_SUCC: begin
                if (r_perm[r_j] > r_perm[r_i]) begin
                    w_ns = NS_SWAP;
                end else begin
                    w_j = r_j - 1'b1;
                end
            end
            NS_SWAP: begin
                w_perm[r_i] = r_perm[r_j];
                w_perm[r_j] = r_perm[r_i];
                w_lo        = w_ip1;
                w_hi        = IDX_LAST;
                if (r_i == IDX_PIV0) begin
                    w_done = 1'b1;
                    w_ns   = NS_IDLE;
                end else begin
                    w_ns = NS_REVERSE;
                end
            end
            NS_REVERSE: begin
                w_perm[r_lo] = r_perm[r_hi];
                w_perm[r_hi] = r_perm[r_lo];
                if ((XW'(r_lo) + XW'(2)) >= XW'(r_hi)) begin
                    w_done = 1'b1;
                    w_ns   = NS_IDLE;
                end else begin
                    w_lo = r_lo + 1'b1;
                    w_hi = r_hi - 1'b1;
                end
            end
            default: begin
                w_ns = NS_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ns   <= NS_IDLE;
            for (int k = 0; k < N; k++) begin
                r_perm[k] <= LW'(k);
            end
            r_i    <= {LW{1'b0}};
            r_j    <= {LW{1'b0}};
            r_lo   <= {LW{1'b0}};
            r_hi   <= {LW{1'b0}};
            r_done <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_ns   <= w_ns;
            r_perm <= w_perm;
            r_i    <= w_i;
            r_j    <= w_j;
            r_lo   <= w_lo;
            r_hi   <= w_hi;
            r_done <= w_done;
            r_last <= w_last;
        end
    end

    // Flatten the permutation: job of worker k in bits [k*LW +: LW].
    always_comb begin
        o_perm = {(N*LW){1'b0}};
        for (int k = 0; k < N; k++) begin
            o_perm[k*LW +: LW] = r_perm[k];
        end
    end

    assign o_done = r_done;
    assign o_last = r_last;

endmodule

// File: rtl/jam_search.sv
// Exhaustive N-worker/N-job assignment solver: loads a cost table from a ROM,
// evaluates every permutation and reports the minimum cost, its multiplicity and first optimum.
module jam_search
    import jam_pkg::*;
#(
    parameter int  N  = 8,
    parameter int  CW = 7,
    localparam int LW = jam_max(1, jam_clog2(N)),
    localparam int SW = CW + jam_clog2(N) + 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            start,
    output logic [LW-1:0]   W,
    output logic [LW-1:0]   J,
    input  logic [CW-1:0]   Cost,
    output logic            busy,
    output logic            Valid,
    output logic [SW-1:0]   MinCost,
    output logic [MW-1:0]   MatchCount,
    output logic [N*LW-1:0] BestPerm
);

    localparam int P = 32'sd1 <<< LW;
    localparam logic [LW-1:0] IDX_LAST = LW'(N - 1);

    function automatic logic [N*LW-1:0] identity_perm();
        logic [N*LW-1:0] r;
        r = {(N*LW){1'b0}};
        for (int k = 0; k < N; k++) begin
            r[k*LW +: LW] = LW'(k);
        end
        return r;
    endfunction

    // Heap-ordered binary tree over a power-of-two leaf count keeps every path equal depth.
    function automatic logic [SW-1:0] tree_sum(input logic [SW-1:0] leaves [P]);
        logic [SW-1:0] node [2*P];
        for (int k = 0; k < 2*P; k++) begin
            node[k] = {SW{1'b0}};
        end
        for (int k = 0; k < P; k++) begin
            node[P+k] = leaves[k];
        end
        for (int k = P - 1; k >= 1; k--) begin
            node[k] = node[2*k] + node[2*k+1];
        end
        return node[1];
    endfunction

    top_state_t      r_state, w_state;
    logic [LW-1:0]   r_widx, w_widx, r_jidx, w_jidx;
    logic            r_busy, w_busy, r_valid, w_valid;
    logic [SW-1:0]   r_min, w_min;
    logic [MW-1:0]   r_cnt, w_cnt;
    logic [N*LW-1:0] r_best, w_best;
    logic [CW-1:0]   r_table [N][N];
    logic [SW-1:0]   w_leaves [P];
    logic [SW-1:0]   w_sum;
    logic            w_np_init, w_np_start, w_np_done, w_np_last;
    logic [N*LW-1:0] w_perm;

    jam_next_perm #(
        .N  (N),
        .LW (LW)
    ) u_next_perm (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_init  (w_np_init),
        .i_start (w_np_start),
        .o_done  (w_np_done),
        .o_last  (w_np_last),
        .o_perm  (w_perm)
    );

    // Cost table capture, row-major during LOAD.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int a = 0; a < N; a++) begin
                for (int b = 0; b < N; b++) begin
                    r_table[a][b] <= {CW{1'b0}};
                end
            end
        end else if (r_state == ST_LOAD) begin
            r_table[r_widx][r_jidx] <= Cost;
        end else begin
            r_table <= r_table;
        end
    end

    // Total cost of the current permutation.
    always_comb begin
        for (int k = 0; k < P; k++) begin
            w_leaves[k] = {SW{1'b0}};
        end
        for (int k = 0; k < N; k++) begin
            w_leaves[k] = SW'(r_table[k][w_perm[k*LW +: LW]]);
        end
        w_sum = tree_sum(w_leaves);
    end

    // Top-level next-state and result update.
    always_comb begin
        w_state    = r_state;
        w_widx     = r_widx;
        w_jidx     = r_jidx;
        w_busy     = r_busy;
        w_valid    = r_valid;
        w_min      = r_min;
        w_cnt      = r_cnt;
        w_best     = r_best;
        w_np_init  = 1'b0;
        w_np_start = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_valid   = 1'b0;
                    w_busy    = 1'b1;
                    w_min     = {SW{1'b1}};
                    w_cnt     = {MW{1'b0}};
                    w_widx    = {LW{1'b0}};
                    w_jidx    = {LW{1'b0}};
                    w_np_init = 1'b1;
                    w_state   = ST_LOAD;
                end else begin
                    w_state = r_state;
                end
            end
            ST_LOAD: begin
                if (r_jidx == IDX_LAST) begin
                    w_jidx = {LW{1'b0}};
                    if (r_widx == IDX_LAST) begin
                        w_widx  = {LW{1'b0}};
                        w_state = ST_EVAL;
                    end else begin
                        w_widx = r_widx + 1'b1;
                    end
                end else begin
                    w_jidx = r_jidx + 1'b1;
                end
            end
            ST_EVAL: begin
                if (w_sum < r_min) begin
                    w_min  = w_sum;
                    w_cnt  = 16'd1;
                    w_best = w_perm;
                end else if (w_sum == r_min) begin
                    w_cnt = r_cnt + 16'd1;
                end else begin
                    w_cnt = r_cnt;
                end
                w_np_start = 1'b1;
                w_state    = ST_NEXT;
            end
            ST_NEXT: begin
                // A "last" result means no successor exists and every permutation is already scored.
                if (w_np_done) begin
                    if (w_np_last) begin
                        w_busy  = 1'b0;
                        w_valid = 1'b1;
                        w_state = ST_DONE;
                    end else begin
                        w_state = ST_EVAL;
                    end
                end else begin
                    w_state = ST_NEXT;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // Top-level state and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_widx  <= {LW{1'b0}};
            r_jidx  <= {LW{1'b0}};
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_min   <= {SW{1'b0}};
            r_cnt   <= {MW{1'b0}};
            r_best  <= identity_perm();
        end else begin
            r_state <= w_state;
            r_widx  <= w_widx;
            r_jidx  <= w_jidx;
            r_busy  <= w_busy;
            r_valid <= w_valid;
            r_min   <= w_min;
            r_cnt   <= w_cnt;
            r_best  <= w_best;
        end
    end

    assign W          = r_widx;
    assign J          = r_jidx;
    assign busy       = r_busy;
    assign Valid      = r_valid;
    assign MinCost    = r_min;
    assign MatchCount = r_cnt;
    assign BestPerm   = r_best;

endmodule

// File: tb/tb_jam_search.sv
// Directed bench for jam_search using N=5, N=3 and N=2 instances so full searches stay short.
module tb_jam_search;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    logic        st5, st3, st2;
    logic [2:0]  w5, j5;
    logic [1:0]  w3, j3;
    logic        w2, j2;
    logic [6:0]  cost5, cost3, cost2;
    logic        busy5, busy3, busy2, valid5, valid3, valid2;
    logic [10:0] min5;
    logic [9:0]  min3;
    logic [8:0]  min2;
    logic [15:0] mc5, mc3, mc2;
    logic [14:0] bp5;
    logic [5:0]  bp3;
    logic [1:0]  bp2;
    int          mode5;

    always #5 clk = ~clk;

    jam_search #(.N(5), .CW(7)) u_dut5 (
        .CLK(clk), .RST_N(rst_n), .start(st5), .W(w5), .J(j5), .Cost(cost5),
        .busy(busy5), .Valid(valid5), .MinCost(min5), .MatchCount(mc5), .BestPerm(bp5)
    );
    jam_search #(.N(3), .CW(7)) u_dut3 (
        .CLK(clk), .RST_N(rst_n), .start(st3), .W(w3), .J(j3), .Cost(cost3),
        .busy(busy3), .Valid(valid3), .MinCost(min3), .MatchCount(mc3), .BestPerm(bp3)
    );
    jam_search #(.N(2), .CW(7)) u_dut2 (
        .CLK(clk), .RST_N(rst_n), .start(st2), .W(w2), .J(j2), .Cost(cost2),
        .busy(busy2), .Valid(valid2), .MinCost(min2), .MatchCount(mc2), .BestPerm(bp2)
    );

    // Cost ROMs.
    always_comb begin
        case (mode5)
            0:       cost5 = 7'd5;
            1:       cost5 = (w5 == j5) ? 7'd0 : 7'd10;
            2:       cost5 = (int'(j5) == 4 - int'(w5)) ? 7'd1 : 7'd50;
            default: cost5 = 7'd127;
        endcase
    end
    assign cost3 = 7'(int'(w3) * 3 + int'(j3));
    assign cost2 = (w2 == j2) ? 7'd3 : 7'd1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] pack5(input int a, input int b, input int c, input int d, input int e);
        return 15'(a | (b << 3) | (c << 6) | (d << 9) | (e << 12));
    endfunction

    task automatic start5();
        @(negedge clk);
        st5 = 1'b1;
        @(posedge clk);
        #1;
        st5 = 1'b0;
    endtask

    task automatic wait5(input string tag);
        int cyc = 0;
        while (valid5 !== 1'b1 && cyc < 5000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_valid"}, 64'(valid5), 64'd1);
    endtask

    task automatic res(input string tag, input logic [63:0] om, input logic [63:0] em,
                       input logic [63:0] oc, input logic [63:0] ec,
                       input logic [63:0] ob, input logic [63:0] eb, input logic obusy);
        chk({tag, "_min"}, om, em);
        chk({tag, "_count"}, oc, ec);
        chk({tag, "_best"}, ob, eb);
        chk({tag, "_busy"}, 64'(obusy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs;
        int cyc;
        rst_n = 1'b0;
        st5 = 1'b0; st3 = 1'b0; st2 = 1'b0;
        mode5 = 0;
        #23;
        chk("rst_busy", 64'(busy5), 64'd0);
        chk("rst_valid", 64'(valid5), 64'd0);
        chk("rst_min", 64'(min5), 64'd0);
        chk("rst_count", 64'(mc5), 64'd0);
        chk("rst_best5", 64'(bp5), 64'(pack5(0, 1, 2, 3, 4)));
        chk("rst_wj", 64'({w5, j5}), 64'd0);
        chk("rst_best3", 64'(bp3), 64'd36);
        chk("rst_best2", 64'(bp2), 64'd2);
        @(negedge clk);
        rst_n = 1'b1;

        mode5 = 0;
        start5();
        chk("t1_busy", 64'(busy5), 64'd1);
        chk("t1_valid_low", 64'(valid5), 64'd0);
        wait5("t1");
        res("t1", 64'(min5), 64'd25, 64'(mc5), 64'd120, 64'(bp5), 64'(pack5(0, 1, 2, 3, 4)), busy5);

        mode5 = 1;
        start5();
        wait5("t2");
        res("t2", 64'(min5), 64'd0, 64'(mc5), 64'd1, 64'(bp5), 64'(pack5(0, 1, 2, 3, 4)), busy5);

        mode5 = 2;
        start5();
        wait5("t3");
        res("t3", 64'(min5), 64'd5, 64'(mc5), 64'd1, 64'(bp5), 64'(pack5(4, 3, 2, 1, 0)), busy5);

        mode5 = 3;
        start5();
        wait5("t4a");
        res("t4a", 64'(min5), 64'd635, 64'(mc5), 64'd120, 64'(bp5), 64'(pack5(0, 1, 2, 3, 4)), busy5);
        mode5 = 1;
        start5();
        chk("t4b_valid_drop", 64'(valid5), 64'd0);
        chk("t4b_min_ones", 64'(min5), 64'd2047);
        chk("t4b_count_clr", 64'(mc5), 64'd0);
        wait5("t4b");
        res("t4b", 64'(min5), 64'd0, 64'(mc5), 64'd1, 64'(bp5), 64'(pack5(0, 1, 2, 3, 4)), busy5);

        // N=3: row-major W/J sweep, with a start pulse mid-load that must be ignored.
        @(negedge clk);
        st3 = 1'b1;
        @(posedge clk);
        #1;
        st3 = 1'b0;
        errs = 0;
        for (int k = 0; k < 9; k++) begin
            if (w3 !== 2'(k / 3) || j3 !== 2'(k % 3)) errs++;
            st3 = (k == 4) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
        end
        st3 = 1'b0;
        chk("t5_load_seq", 64'(errs), 64'd0);
        chk("t5_wj_after_load", 64'({w3, j3}), 64'd0);
        chk("t5_busy", 64'(busy3), 64'd1);
        cyc = 0;
        while (valid3 !== 1'b1 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t5_valid", 64'(valid3), 64'd1);
        res("t5", 64'(min3), 64'd12, 64'(mc3), 64'd6, 64'(bp3), 64'd36, busy3);

        // N=2 edge case: identity sums 6, swap sums 2.
        @(negedge clk);
        st2 = 1'b1;
        @(posedge clk);
        #1;
        st2 = 1'b0;
        cyc = 0;
        while (valid2 !== 1'b1 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("n2_valid", 64'(valid2), 64'd1);
        res("n2", 64'(min2), 64'd2, 64'(mc2), 64'd1, 64'(bp2), 64'd1, busy2);

        // Asynchronous reset in the middle of the search, then a normal run.
        mode5 = 0;
        start5();
        repeat (40) @(posedge clk);
        #3;
        chk("t6_busy_before", 64'(busy5), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy5), 64'd0);
        chk("t6_valid", 64'(valid5), 64'd0);
        chk("t6_min", 64'(min5), 64'd0);
        chk("t6_count", 64'(mc5), 64'd0);
        chk("t6_best", 64'(bp5), 64'(pack5(0, 1, 2, 3, 4)));
        chk("t6_wj", 64'({w5, j5}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode5 = 2;
        start5();
        wait5("t6_after");
        res("t6_after", 64'(min5), 64'd5, 64'(mc5), 64'd1, 64'(bp5), 64'(pack5(4, 3, 2, 1, 0)), busy5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
